progressive_mux_sequencer: RTL
==============================

# progressive_mux_sequencer

Controller that drives the `alpha_sequence` and `enable_compute` inputs of `progressive_mux`, which crossfades between `data_a` and `data_b`. It accepts switch requests through a req/ack handshake and ramps alpha one LSB at a time between 0 (100 % `data_a`) and 16 (100 % `data_b`). Alpha updates occur only on `enable_3M` ticks, so the mux sees alpha changes aligned to its own compute rate. It sits beside `progressive_mux` in the same `clk` domain and is driven by the channel-select logic.

## Interface
- `STEP_DIV`, default 1: number of `enable_3M` ticks per alpha step. Must be ≥ 1. The step counter width is `$clog2(STEP_DIV+1)`.

- `clk` in 1: system clock (24 MHz).
- `reset` in 1: asynchronous, active-low reset.
- `enable_3M` in 1: one-clk compute strobe.
- `switch_req` in 1: level request. Held by the requester until `switch_ack`.
- `target_sel` in 1: requested side, 0 = A, 1 = B. Stable while `switch_req` is high.
- `switch_ack` out 1: one-clk pulse when the request is accepted.
- `alpha_sequence` out 5: ramp value in 00.000..10.000 fixed point, range 0..16.
- `enable_compute` out 1: high for exactly one 3M period at ramp start.
- `busy` out 1: high while state ≠ IDLE.
- `done` out 1: one-clk pulse when a switch completes.
- `sel_current` out 1: side currently fully selected.

## Operation
- States:
  - IDLE: alpha sits at an endpoint.
  - ARM: accepted, waiting for the next tick.
  - RAMP: stepping.
- IDLE, `switch_req`=1:
  - `switch_ack` pulses the next clk, and the target is latched.
  - If `target_sel == sel_current`: stay in IDLE and pulse `done` in the same clk as the ack. There is no alpha change and no `enable_compute`.
  - Otherwise: go to ARM. The direction is up if the target is B, down if the target is A.
- ARM: on the first `enable_3M` tick strictly after the accept clk, set `enable_compute`=1, clear the step counter, and go to RAMP.
- RAMP, on each `enable_3M` tick:
  - Clear `enable_compute` (so it lasts one 3M period).
  - Increment the step counter.
  - When the counter reaches `STEP_DIV`, add ±1 to alpha and clear the counter.
  - When alpha reaches the endpoint (16 up, 0 down): go to IDLE, set `sel_current` to the target, pulse `done`, and drop `busy`, all in the same clk.
- Alpha saturates. It never leaves 0..16, and there is no wrap.
- `switch_req` while busy: handling depends on the `PMUX_SEQ_REVERSE_EN` configuration (see Configuration).
- Completion and reversal request in the same clk: completion wins. The request is then evaluated in IDLE on the next clk.

## Timing
- Reset (asynchronous, while low) forces:
  - `alpha_sequence`=0, `sel_current`=0, `enable_compute`=0
  - `switch_ack`=0, `done`=0, `busy`=0
  - state IDLE, step counter 0
- Reset mid-ramp aborts immediately. Any pending request is dropped and must be re-presented.
- Request to ack latency: 1 clk.
- `enable_compute` rises on tick T0, the first tick after ARM entry.
- With `STEP_DIV`=1:
  - Alpha changes on T1..T16.
  - `done` pulses on the T16 clk.
- A full ramp takes 16·`STEP_DIV` ticks after T0.
- All outputs are registered.

## Configuration
- `PMUX_SEQ_REVERSE_EN` defined: mid-switch reversal is enabled.
  - In ARM or RAMP, a request whose target differs from the latched target is acked in 1 clk and the latched target flips.
  - In RAMP, alpha reverses direction from its current value on the next step. The step counter is not cleared.
  - In ARM, if the new target equals `sel_current`: return to IDLE, pulse `done`, and never raise `enable_compute`.
  - A request equal to the latched target is acked with no other effect.
- `PMUX_SEQ_REVERSE_EN` undefined: `switch_ack` is withheld while `busy`=1. The request is accepted in IDLE the clk after `done`.

## Test plan
- Reset: assert reset mid-sim. All outputs must match the reset values listed under Timing within the same clk, with no dependence on `clk`.
- `STEP_DIV`=1, IDLE, req B:
  - `switch_ack` pulses 1 clk after the request.
  - `enable_compute` is high for one 3M period with alpha=0.
  - Alpha takes 1..16 on ticks T1..T16.
  - `done` pulses at T16, after which `sel_current`=1 and `busy`=0.
- Same-side request (`sel_current`=0, req A): `switch_ack` and `done` pulse in the same clk. There is no `enable_compute` and alpha stays at 0.
- Reversal:
  - Setup: req B, then req A when alpha=5.
  - With `PMUX_SEQ_REVERSE_EN`: ack in 1 clk, alpha steps 4,3,…,0, `done`, `sel_current`=0, and there is no second `enable_compute`.
  - Without it: no ack until after `done` at alpha=16, then a full 16-step ramp down with a new `enable_compute`.
- `STEP_DIV`=3: alpha changes every 3rd tick, and `done` pulses 48 ticks after T0.
- Async reset at alpha=9 during a ramp: alpha=0 and `busy`=0 immediately. A fresh req B afterwards performs a normal full ramp.

Source files
------------

// File: rtl/progressive_mux_sequencer_if.sv
// progressive_mux_sequencer_if
// Groups the request handshake and the alpha/compute controls exchanged
// between the channel-select logic (master) and progressive_mux_sequencer
// (slave). clk and reset are kept as plain ports on the sequencer.
//   enable_3M      : one-clk compute strobe (master -> slave)
//   switch_req     : level switch request, held until switch_ack
//   target_sel     : requested side, 0 = data_a, 1 = data_b
//   switch_ack     : one-clk accept pulse (slave -> master)
//   alpha_sequence : crossfade value 0..16
//   enable_compute : high for one 3M period at ramp start
//   busy           : sequencer not idle
//   done           : one-clk completion pulse
//   sel_current    : side currently fully selected
interface progressive_mux_sequencer_if;
    logic       enable_3M;
    logic       switch_req;
    logic       target_sel;
    logic       switch_ack;
    logic [4:0] alpha_sequence;
    logic       enable_compute;
    logic       busy;
    logic       done;
    logic       sel_current;

    modport master (
        output enable_3M, switch_req, target_sel,
        input  switch_ack, alpha_sequence, enable_compute, busy, done, sel_current
    );

    modport slave (
        input  enable_3M, switch_req, target_sel,
        output switch_ack, alpha_sequence, enable_compute, busy, done, sel_current
    );
endinterface

// File: rtl/progressive_mux_sequencer.sv
// progressive_mux_sequencer
// Drives alpha_sequence / enable_compute of progressive_mux. A switch request
// ramps alpha one LSB per STEP_DIV enable_3M ticks between 0 (all data_a)
// and 16 (all data_b). All outputs are registered.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : progressive_mux_sequencer_if.slave (enable_3M, switch_req,
//           target_sel in; switch_ack, alpha_sequence, enable_compute, busy,
//           done, sel_current out)
// Parameter STEP_DIV (>= 1): enable_3M ticks per alpha step.
// Optional macro PMUX_SEQ_REVERSE_EN: accept requests while busy, reversing
// an in-flight switch. Without it requests wait until the sequencer is idle.
module progressive_mux_sequencer #(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    progressive_mux_sequencer_if.slave bus
);
    localparam int unsigned   CW        = $clog2(STEP_DIV + 1);
    localparam logic [CW-1:0] DIV       = CW'(STEP_DIV);
    localparam logic [4:0]    ALPHA_MAX = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RAMP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    alpha_q, alpha_d;
    logic          target_q, target_d;
    logic          sel_q, sel_d;
    logic          ack_q, ack_d;
    logic          done_q, done_d;
    logic          ec_q, ec_d;
    logic          busy_q, busy_d;

    logic          req_new;
    logic          rev_req;
    logic          keep_req;
    logic [CW-1:0] cnt_inc;
    logic          step_hit;
    logic [4:0]    alpha_step;
    logic          ramp_end;

    // ack_q masks the request that is still held during its own ack clk
    assign req_new    = bus.switch_req && !ack_q;
    assign cnt_inc    = cnt_q + CW'(1);
    assign step_hit   = (cnt_inc == DIV);
    // Direction always follows the latched target; saturate at the endpoints
    assign alpha_step = target_q ? ((alpha_q >= ALPHA_MAX) ? ALPHA_MAX : alpha_q + 5'd1)
                                 : ((alpha_q == 5'd0)      ? 5'd0      : alpha_q - 5'd1);
    assign ramp_end   = bus.enable_3M && step_hit &&
                        (alpha_step == (target_q ? ALPHA_MAX : 5'd0));

`ifdef PMUX_SEQ_REVERSE_EN
    assign rev_req  = req_new && (state_q != IDLE) && (bus.target_sel != target_q);
    assign keep_req = req_new && (state_q != IDLE) && (bus.target_sel == target_q);
`else
    assign rev_req  = 1'b0;
    assign keep_req = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alpha_q  <= '0;
            target_q <= 1'b0;
            sel_q    <= 1'b0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            ec_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alpha_q  <= alpha_d;
            target_q <= target_d;
            sel_q    <= sel_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            ec_q     <= ec_d;
            busy_q   <= busy_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_new && (bus.target_sel != sel_q)) state_d = ARM;
            ARM: begin
                // In ARM a differing target always equals sel_current: abort
                if (rev_req)            state_d = IDLE;
                else if (bus.enable_3M) state_d = RAMP;
            end
            RAMP: if (ramp_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next register values for the outputs and datapath
    always_comb begin
        cnt_d    = cnt_q;
        alpha_d  = alpha_q;
        target_d = target_q;
        sel_d    = sel_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;
        ec_d     = ec_q;
        busy_d   = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (req_new) begin
                    ack_d    = 1'b1;
                    target_d = bus.target_sel;
                    if (bus.target_sel == sel_q) done_d = 1'b1;
                end
            end
            ARM: begin
                if (rev_req || keep_req) ack_d = 1'b1;
                if (rev_req) begin
                    target_d = ~target_q;
                    done_d   = 1'b1;
                end else if (bus.enable_3M) begin
                    ec_d  = 1'b1;
                    cnt_d = '0;
                end
            end
            RAMP: begin
                if (bus.enable_3M) begin
                    ec_d  = 1'b0;
                    cnt_d = step_hit ? '0 : cnt_inc;
                    if (step_hit) alpha_d = alpha_step;
                    if (ramp_end) begin
                        sel_d  = target_q;
                        done_d = 1'b1;
                    end
                end
                // Completion wins; a same-clk request is re-evaluated from IDLE.
                // A reversal keeps the step counter so the next step reverses.
                if (!ramp_end) begin
                    if (rev_req || keep_req) ack_d = 1'b1;
                    if (rev_req) target_d = ~target_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.switch_ack     = ack_q;
    assign bus.alpha_sequence = alpha_q;
    assign bus.enable_compute = ec_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.sel_current    = sel_q;
endmodule
